trig_sync_initiator: RTL and testbench
======================================

TRIG_SYNC_INITIATOR -- requirements
Module: trig_sync_initiator

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, sysClk cycles to wait for syncIn after each resetReqOut pulse (legal 2..65535).
REQ-002 Parameter MAX_RETRY, default 3, re-requests allowed after the first timeout before failing (legal 0..15).
REQ-003 sysClk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 armCmd  in  1  user sync request; level sampled each cycle, acted on only in IDLE.
REQ-006 trig  in  1  machine trigger, one-cycle pulse per turn.
REQ-007 syncIn  in  1  one-cycle sync acknowledge from the trigger-sync responder.
REQ-008 resetReqOut  out  1  one-cycle request to the responder's reset-trigger input.
REQ-009 turnCount  out  32  registered count of trig pulses since last successful sync.
REQ-010 syncBusy  out  1  high while a request/wait sequence is in progress.
REQ-011 syncDone  out  1  one-cycle pulse when sync completes.
REQ-012 timeoutErr  out  1  sticky failure flag after retries are exhausted.
REQ-013 retryCnt  out  4  re-requests issued in the current/last sequence.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, DONE, FAIL; all outputs registered.
REQ-015 IDLE: armCmd=1 -> REQ, clear retryCnt and timeoutErr; else stay.
REQ-016 REQ: resetReqOut=1 for exactly this one cycle, clear wait counter, -> WAIT.
REQ-017 WAIT: wait counter +1 per cycle; syncIn=1 -> DONE; counter reaching TIMEOUT_CYC-1 without syncIn -> timeout.
REQ-018 Timeout with retryCnt < MAX_RETRY: retryCnt +1, -> REQ; with retryCnt = MAX_RETRY: -> FAIL.
REQ-019 syncIn and timeout in same cycle: syncIn wins, -> DONE.
REQ-020 syncIn outside WAIT is ignored (no state, counter or flag change).
REQ-021 DONE: syncDone=1 for one cycle, -> IDLE.
REQ-022 FAIL: set timeoutErr=1, -> IDLE; timeoutErr holds until next armCmd accepted or reset.
REQ-023 syncBusy=1 in REQ and WAIT, 0 otherwise.
REQ-024 turnCount increments by 1 on every trig in any state; wraps 0xFFFFFFFF -> 0 without flag.
REQ-025 syncIn accepted in WAIT loads turnCount to 0; a coincident trig that cycle is not counted.
REQ-026 armCmd during REQ/WAIT/DONE/FAIL ignored; held armCmd retriggers on first IDLE cycle.
REQ-027 Latency: armCmd sampled in IDLE -> resetReqOut high on the next cycle's output; syncIn in WAIT -> syncDone high next cycle, turnCount=0 same edge.

Reset
REQ-028 reset=0 at a clock edge: state IDLE, resetReqOut=0, syncBusy=0, syncDone=0, timeoutErr=0, retryCnt=0, turnCount=0, wait counter=0.
REQ-029 Reset mid-sequence aborts without a syncDone or timeoutErr pulse; reset dominates all inputs.

Verification
REQ-030 Normal: reset, 5 trig -> turnCount=5; armCmd 1 cycle -> one resetReqOut pulse; syncIn 10 cycles later -> syncDone 1 cycle, turnCount=0, retryCnt=0.
REQ-031 Retry: TIMEOUT_CYC=16, MAX_RETRY=3, no syncIn -> 4 resetReqOut pulses 16+1 cycles apart, then timeoutErr=1, retryCnt=3, syncBusy=0.
REQ-032 Late success: syncIn during 2nd WAIT -> syncDone, retryCnt=1, timeoutErr=0.
REQ-033 Corners: syncIn on timeout cycle -> DONE; syncIn + trig same cycle -> turnCount=0; stray syncIn in IDLE -> no effect.
REQ-034 Wrap/reset: preload to 0xFFFFFFFF via trigs, one trig -> 0; reset asserted in WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/trig_sync_initiator.sv
// Trigger-sync initiator: issues reset-trigger requests to a responder, waits for its
// acknowledge with timeout/retry, and counts machine trigger turns between syncs.
//
// state | meaning
// IDLE  | waiting for armCmd; timeoutErr from a failed sequence is held here
// REQ   | resetReqOut pulse cycle; wait counter cleared
// WAIT  | counting cycles for syncIn; timeout re-requests or fails
// DONE  | syncDone pulse cycle after an accepted syncIn
// FAIL  | retries exhausted; timeoutErr raised
module trig_sync_initiator #(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        sysClk,
   input  logic        reset,
   input  logic        armCmd,
   input  logic        trig,
   input  logic        syncIn,
   output logic        resetReqOut,
   output logic [31:0] turnCount,
   output logic        syncBusy,
   output logic        syncDone,
   output logic        timeoutErr,
   output logic [3:0]  retryCnt
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      FAIL
   } stateT;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   stateT       state;
   logic [15:0] waitCnt;

   // Outputs are registered from the next state so each one reflects the state being entered.
   always_ff @(posedge sysClk) begin
      if (!reset) begin
         state       <= IDLE;
         waitCnt     <= '0;
         resetReqOut <= 1'b0;
         turnCount   <= '0;
         syncBusy    <= 1'b0;
         syncDone    <= 1'b0;
         timeoutErr  <= 1'b0;
         retryCnt    <= '0;
      end else begin
         resetReqOut <= 1'b0;
         syncDone    <= 1'b0;

         // An accepted acknowledge restarts the turn count and swallows a coincident trig.
         if (state == WAIT && syncIn) begin
            turnCount <= '0;
         end else if (trig) begin
            turnCount <= turnCount + 32'd1;
         end

         case (state)
            IDLE: begin
               if (armCmd) begin
                  state       <= REQ;
                  resetReqOut <= 1'b1;
                  syncBusy    <= 1'b1;
                  retryCnt    <= '0;
                  timeoutErr  <= 1'b0;
               end
            end
            REQ: begin
               waitCnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (syncIn) begin
                  state    <= DONE;
                  syncDone <= 1'b1;
                  syncBusy <= 1'b0;
               end else if (waitCnt == WAIT_LAST) begin
                  if (retryCnt < RETRY_MAX) begin
                     retryCnt    <= retryCnt + 4'd1;
                     state       <= REQ;
                     resetReqOut <= 1'b1;
                  end else begin
                     state      <= FAIL;
                     timeoutErr <= 1'b1;
                     syncBusy   <= 1'b0;
                  end
               end else begin
                  waitCnt <= waitCnt + 16'd1;
               end
            end
            DONE: state <= IDLE;
            FAIL: state <= IDLE;
            default: begin
               state    <= IDLE;
               syncBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trig_sync_initiator.sv
// Bench for trig_sync_initiator: vector table, multi-cycle corner sequences, then
// random stimulus against a timestamp-based reference model.
module tb_trig_sync_initiator;

   localparam int TO = 16;
   localparam int MR = 3;

   logic        sysClk = 1'b0;
   logic        reset  = 1'b0;
   logic        armCmd = 1'b0;
   logic        trig   = 1'b0;
   logic        syncIn = 1'b0;
   logic        resetReqOut;
   logic [31:0] turnCount;
   logic        syncBusy;
   logic        syncDone;
   logic        timeoutErr;
   logic [3:0]  retryCnt;

   int vecs    = 0;
   int miscmp  = 0;

   always #5 sysClk = ~sysClk;

   trig_sync_initiator #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
      .sysClk      (sysClk),
      .reset       (reset),
      .armCmd      (armCmd),
      .trig        (trig),
      .syncIn      (syncIn),
      .resetReqOut (resetReqOut),
      .turnCount   (turnCount),
      .syncBusy    (syncBusy),
      .syncDone    (syncDone),
      .timeoutErr  (timeoutErr),
      .retryCnt    (retryCnt)
   );

   typedef struct {
      int r, a, t, s;
      int rro, busy, done, err, rc;
      logic [31:0] tc;
   } vec_t;

   vec_t tbl[25];

   // reference model: sequence described by the edge index of the latest request pulse
   int          mEdge, mActive, mCool, mErr, mDone, mLastReq, mRetries;
   logic [31:0] mTurns;

   function automatic logic [39:0] snap();
      return {resetReqOut, syncBusy, syncDone, timeoutErr, retryCnt, turnCount};
   endfunction

   function automatic logic [39:0] expv(int rro, int busy, int done, int err, int rc, logic [31:0] tc);
      return {1'(rro), 1'(busy), 1'(done), 1'(err), 4'(rc), tc};
   endfunction

   task automatic step(int r, int a, int t, int s);
      reset  = (r != 0);
      armCmd = (a != 0);
      trig   = (t != 0);
      syncIn = (s != 0);
      @(posedge sysClk);
      #1;
   endtask

   task automatic chk(string name, logic [39:0] act, logic [39:0] want);
      vecs++;
      if (act !== want) begin
         miscmp++;
         $display("FAIL %s: got rro/busy/done/err=%b retry=%0d turns=%h, expected rro/busy/done/err=%b retry=%0d turns=%h",
                  name, act[39:36], act[35:32], act[31:0], want[39:36], want[35:32], want[31:0]);
      end
   endtask

   task automatic chkInt(string name, int act, int want);
      vecs++;
      if (act != want) begin
         miscmp++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   task automatic modelEdge(int r, int a, int t, int s);
      int coolPrev, waiting, ok, elapsed;
      mEdge++;
      if (r == 0) begin
         mActive = 0; mCool = 0; mErr = 0; mDone = 0;
         mRetries = 0; mTurns = '0; mLastReq = -100;
         return;
      end
      coolPrev = mCool;
      mCool    = 0;
      waiting  = (mActive != 0 && mEdge - 1 > mLastReq) ? 1 : 0;
      elapsed  = mEdge - mLastReq - 2;
      ok       = (waiting != 0 && s != 0) ? 1 : 0;
      mTurns   = (ok != 0) ? 32'd0 : mTurns + 32'(t);
      mDone    = ok;
      if (ok != 0) begin
         mActive = 0;
         mCool   = 1;
      end else if (waiting != 0 && elapsed == TO - 1) begin
         if (mRetries < MR) begin
            mRetries++;
            mLastReq = mEdge;
         end else begin
            mActive = 0;
            mErr    = 1;
            mCool   = 1;
         end
      end else if (mActive == 0 && coolPrev == 0 && a != 0) begin
         mActive  = 1;
         mLastReq = mEdge;
         mRetries = 0;
         mErr     = 0;
      end
   endtask

   initial begin
      int pulses[$];
      int errAt;

      //            r a t s  rro busy done err rc  tc
      tbl[0]  = '{0,0,0,0, 0,0,0,0,0, 0};
      tbl[1]  = '{1,0,1,0, 0,0,0,0,0, 1};
      tbl[2]  = '{1,0,1,0, 0,0,0,0,0, 2};
      tbl[3]  = '{1,0,1,0, 0,0,0,0,0, 3};
      tbl[4]  = '{1,0,1,0, 0,0,0,0,0, 4};
      tbl[5]  = '{1,0,1,0, 0,0,0,0,0, 5};
      tbl[6]  = '{1,1,0,0, 1,1,0,0,0, 5};
      tbl[7]  = '{1,0,0,0, 0,1,0,0,0, 5};
      tbl[8]  = '{1,0,0,0, 0,1,0,0,0, 5};
      tbl[9]  = '{1,0,0,0, 0,1,0,0,0, 5};
      tbl[10] = '{1,0,1,0, 0,1,0,0,0, 6};
      tbl[11] = '{1,0,0,0, 0,1,0,0,0, 6};
      tbl[12] = '{1,0,0,0, 0,1,0,0,0, 6};
      tbl[13] = '{1,0,0,0, 0,1,0,0,0, 6};
      tbl[14] = '{1,0,0,0, 0,1,0,0,0, 6};
      tbl[15] = '{1,0,0,0, 0,1,0,0,0, 6};
      tbl[16] = '{1,0,0,0, 0,1,0,0,0, 6};
      tbl[17] = '{1,0,1,1, 0,0,1,0,0, 0};
      tbl[18] = '{1,0,0,0, 0,0,0,0,0, 0};
      tbl[19] = '{1,0,1,1, 0,0,0,0,0, 1};
      tbl[20] = '{1,0,0,1, 0,0,0,0,0, 1};
      tbl[21] = '{1,1,0,0, 1,1,0,0,0, 1};
      tbl[22] = '{1,1,1,0, 0,1,0,0,0, 2};
      tbl[23] = '{0,1,1,1, 0,0,0,0,0, 0};
      tbl[24] = '{1,0,0,0, 0,0,0,0,0, 0};

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].r, tbl[i].a, tbl[i].t, tbl[i].s);
         chk($sformatf("vec%0d", i), snap(),
             expv(tbl[i].rro, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].rc, tbl[i].tc));
      end

      // retries exhausted: four pulses 17 cycles apart, then sticky timeoutErr
      errAt = -1;
      step(1, 1, 0, 0);
      if (resetReqOut) pulses.push_back(0);
      for (int c = 1; c < 150 && errAt < 0; c++) begin
         step(1, 0, 0, 0);
         if (resetReqOut) pulses.push_back(c);
         if (timeoutErr) errAt = c;
      end
      chkInt("retry_pulse_count", pulses.size(), 4);
      for (int i = 1; i < pulses.size(); i++)
         chkInt($sformatf("retry_gap%0d", i), pulses[i] - pulses[i-1], TO + 1);
      chkInt("fail_reached", (errAt >= 0) ? 1 : 0, 1);
      if (errAt >= 0 && pulses.size() > 0)
         chkInt("fail_latency", errAt - pulses[pulses.size()-1], TO + 1);
      chk("fail_state", snap(), expv(0, 0, 0, 1, MR, 0));
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      chk("err_sticky", snap(), expv(0, 0, 0, 1, MR, 0));

      // late success in the second wait window
      step(1, 1, 0, 0);
      chk("rearm_clears_err", snap(), expv(1, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 16; i++) step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("second_req", snap(), expv(1, 1, 0, 0, 1, 0));
      step(1, 0, 0, 1);
      chk("syncin_in_req_ignored", snap(), expv(0, 1, 0, 0, 1, 0));
      step(1, 0, 1, 0);
      chk("trig_in_wait", snap(), expv(0, 1, 0, 0, 1, 1));
      step(1, 0, 0, 1);
      chk("late_success", snap(), expv(0, 0, 1, 0, 1, 0));
      step(1, 0, 0, 0);
      chk("late_success_idle", snap(), expv(0, 0, 0, 0, 1, 0));

      // syncIn on the timeout cycle wins
      step(1, 1, 0, 0);
      chk("corner_arm", snap(), expv(1, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 16; i++) step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      chk("sync_on_timeout", snap(), expv(0, 0, 1, 0, 0, 0));
      step(1, 0, 0, 0);

      // wrap of the turn counter from an all-ones preload
      force dut.turnCount = 32'hFFFF_FFFF;
      #1;
      release dut.turnCount;
      #1;
      chk("preload", snap(), expv(0, 0, 0, 0, 0, 32'hFFFF_FFFF));
      step(1, 0, 1, 0);
      chk("wrap", snap(), expv(0, 0, 0, 0, 0, 0));
      step(1, 0, 1, 0);
      chk("after_wrap", snap(), expv(0, 0, 0, 0, 0, 1));

      // random stimulus against the reference model
      mEdge = 0;
      for (int i = 0; i < 3000; i++) begin
         int r, a, t, s;
         r = (i == 0) ? 0 : (($urandom_range(299, 0) != 0) ? 1 : 0);
         a = ($urandom_range(19, 0) == 0) ? 1 : 0;
         t = ($urandom_range(3, 0) == 0) ? 1 : 0;
         s = ($urandom_range(24, 0) == 0) ? 1 : 0;
         step(r, a, t, s);
         modelEdge(r, a, t, s);
         chk($sformatf("rand%0d", i), snap(),
             expv((mActive != 0 && mLastReq == mEdge) ? 1 : 0, mActive, mDone, mErr, mRetries, mTurns));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
